// File: rtl/data_bus_arb.sv
// Two-master arbiter onto a single data-memory port.
// Only one transaction is outstanding at a time: request, grant, then wait for rvalid.
module data_bus_arb #(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        data_req_o,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   sel;
  logic   cur_owner;
  logic   bus_req;
  logic   resp;
  logic   req_en;
  logic   resp_en;

  always_comb begin
    sel = 1'b0;
    if (m0_req_i && m1_req_i) begin
      sel = (RR_EN != 0) ? ~last_grant_q : 1'b0;
    end else if (m1_req_i) begin
      sel = 1'b1;
    end

    state_d   = state_q;
    owner_d   = owner_q;
    cur_owner = owner_q;
    bus_req   = 1'b0;
    resp      = 1'b0;

    case (state_q)
      IDLE: begin
        cur_owner = sel;
        bus_req   = m0_req_i | m1_req_i;
        if (bus_req) begin
          owner_d = sel;
          state_d = data_gnt_i ? RESP : REQ;
        end
      end
      REQ: begin
        // Owner is locked here; a dropped request abandons the attempt.
        bus_req = owner_q ? m1_req_i : m0_req_i;
        if (!bus_req) begin
          state_d = IDLE;
        end else if (data_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          resp    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    last_grant_d = (bus_req && data_gnt_i) ? cur_owner : last_grant_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs are combinational, so they are forced quiet while reset is held.
  always_comb begin
    req_en       = bus_req & ~rst_i;
    resp_en      = resp & ~rst_i;

    data_req_o   = req_en;
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (req_en) begin
      data_addr_o  = cur_owner ? m1_addr_i  : m0_addr_i;
      data_we_o    = cur_owner ? m1_we_i    : m0_we_i;
      data_be_o    = cur_owner ? m1_be_i    : m0_be_i;
      data_wdata_o = cur_owner ? m1_wdata_i : m0_wdata_i;
    end

    m0_gnt_o    = req_en & data_gnt_i & ~cur_owner;
    m1_gnt_o    = req_en & data_gnt_i &  cur_owner;
    m0_rvalid_o = resp_en & ~owner_q;
    m1_rvalid_o = resp_en &  owner_q;
    m0_rdata_o  = m0_rvalid_o ? data_rdata_i : '0;
    m1_rdata_o  = m1_rvalid_o ? data_rdata_i : '0;
  end

endmodule

// File: tb/tb_data_bus_arb.sv
// Directed bench for data_bus_arb: a round-robin instance checked through a
// response scoreboard, plus a fixed-priority instance for the priority case.
module tb_data_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;

  logic        r_m0_gnt, r_m1_gnt, r_m0_rvalid, r_m1_rvalid, r_data_req, r_data_we;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_data_addr, r_data_wdata;
  logic [3:0]  r_data_be;
  logic        f_m0_gnt, f_m1_gnt, f_m0_rvalid, f_m1_rvalid, f_data_req, f_data_we;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_data_addr, f_data_wdata;
  logic [3:0]  f_data_be;

  typedef struct {
    logic        m;
    logic [31:0] d;
    bit          cd;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_arb #(.RR_EN(1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(r_m0_gnt), .m0_rvalid_o(r_m0_rvalid), .m0_rdata_o(r_m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(r_m1_gnt), .m1_rvalid_o(r_m1_rvalid), .m1_rdata_o(r_m1_rdata),
    .data_req_o(r_data_req), .data_addr_o(r_data_addr), .data_we_o(r_data_we),
    .data_be_o(r_data_be), .data_wdata_o(r_data_wdata),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
  );

  data_bus_arb #(.RR_EN(0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(f_m0_gnt), .m0_rvalid_o(f_m0_rvalid), .m0_rdata_o(f_m0_rdata),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(f_m1_gnt), .m1_rvalid_o(f_m1_rvalid), .m1_rdata_o(f_m1_rdata),
    .data_req_o(f_data_req), .data_addr_o(f_data_addr), .data_we_o(f_data_we),
    .data_be_o(f_data_be), .data_wdata_o(f_data_wdata),
    .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Response monitor for the round-robin instance.
  always @(negedge clk) begin
    exp_t e;
    if (r_m0_rvalid || r_m1_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", {30'd0, r_m1_rvalid, r_m0_rvalid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_onehot", {30'd0, r_m1_rvalid, r_m0_rvalid}, e.m ? 32'd2 : 32'd1);
        if (e.cd) chk("resp_rdata", e.m ? r_m1_rdata : r_m0_rdata, e.d);
        chk("resp_other_rdata", e.m ? r_m0_rdata : r_m1_rdata, 32'd0);
      end
    end
  end

  initial begin
    logic        exp_o;
    logic [31:0] rd;
    rst = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_be = '0; m1_be = '0;
    data_gnt = 0; data_rvalid = 0; data_rdata = '0;

    // Reset: outputs quiet even with all inputs active
    #3;
    m0_req = 1; m1_req = 1; data_gnt = 1; data_rvalid = 1; data_rdata = 32'hFFFF_FFFF;
    m0_addr = 32'h55; m0_be = 4'hF;
    #1;
    chk1("rst_data_req", r_data_req, 1'b0);
    chk("rst_data_addr", r_data_addr, 32'd0);
    chk1("rst_m0_gnt", r_m0_gnt, 1'b0);
    chk1("rst_m1_gnt", r_m1_gnt, 1'b0);
    chk1("rst_m0_rvalid", r_m0_rvalid, 1'b0);
    chk("rst_m0_rdata", r_m0_rdata, 32'd0);
    m0_req = 0; m1_req = 0; data_gnt = 0; data_rvalid = 0; data_rdata = '0;
    m0_addr = '0; m0_be = '0;
    cyc(); cyc();
    rst = 1'b0;

    // Single m0 read, gnt in cycle 0, rvalid in cycle 2
    cyc();
    m0_req = 1; m0_addr = 32'h100; m0_be = 4'hF; data_gnt = 1;
    settle();
    chk1("rd_data_req", r_data_req, 1'b1);
    chk("rd_data_addr", r_data_addr, 32'h100);
    chk("rd_data_be", {28'd0, r_data_be}, 32'hF);
    chk1("rd_m0_gnt", r_m0_gnt, 1'b1);
    chk1("rd_m1_gnt", r_m1_gnt, 1'b0);
    cyc();
    m0_req = 0; data_gnt = 0;
    settle();
    chk1("rd_wait_req", r_data_req, 1'b0);
    chk("rd_wait_addr", r_data_addr, 32'd0);
    cyc();
    data_rvalid = 1; data_rdata = 32'hDEAD_BEEF;
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1});
    settle();
    chk1("rd_m1_rvalid", r_m1_rvalid, 1'b0);
    chk("rd_m1_rdata", r_m1_rdata, 32'd0);
    cyc();
    data_rvalid = 0;
    settle();
    chk1("rd_after_rvalid", r_m0_rvalid, 1'b0);
    chk("rd_after_rdata", r_m0_rdata, 32'd0);

    // Spurious rvalid in IDLE, then an m1 transaction proves IDLE was kept
    cyc();
    data_rvalid = 1; data_rdata = 32'h1234_5678;
    settle();
    chk1("spur_m0_rvalid", r_m0_rvalid, 1'b0);
    chk1("spur_m1_rvalid", r_m1_rvalid, 1'b0);
    cyc();
    data_rvalid = 0; m1_req = 1; m1_addr = 32'h180; data_gnt = 1;
    settle();
    chk1("spur_m1_gnt", r_m1_gnt, 1'b1);
    chk("spur_addr", r_data_addr, 32'h180);
    cyc();
    m1_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'hA5A5_0001;
    exp_q.push_back('{1'b1, 32'hA5A5_0001, 1'b1});
    cyc();
    data_rvalid = 0;

    // Round robin: m0 reads, m1 writes, both requesting continuously
    m0_req = 1; m1_req = 1; m0_be = 4'hF; m1_be = 4'h3; m1_we = 1; data_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h200 + 32'(i * 4); m1_addr = 32'h300 + 32'(i * 4);
      m1_wdata = 32'h5500 + 32'(i);
      data_rvalid = 0;
      exp_o = i[0];
      settle();
      chk1("rr_m0_gnt", r_m0_gnt, ~exp_o);
      chk1("rr_m1_gnt", r_m1_gnt, exp_o);
      chk("rr_addr", r_data_addr, exp_o ? m1_addr : m0_addr);
      chk1("rr_we", r_data_we, exp_o);
      chk("rr_wdata", r_data_wdata, exp_o ? m1_wdata : 32'd0);
      cyc();
      rd = 32'hC0DE_0000 + 32'(i);
      data_rvalid = 1; data_rdata = rd;
      exp_q.push_back('{exp_o, rd, ~exp_o});
      settle();
      chk1("rr_resp_no_req", r_data_req, 1'b0);
      chk1("rr_resp_no_gnt", r_m0_gnt | r_m1_gnt, 1'b0);
      cyc();
    end
    data_rvalid = 0; m0_req = 0; m1_req = 0; m1_we = 0; data_gnt = 0;

    // Fixed priority on u_fp; u_rr sees the same traffic and alternates
    rst = 1; cyc(); rst = 0;
    m0_req = 1; m1_req = 1; data_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h600 + 32'(i * 4); m1_addr = 32'h700 + 32'(i * 4);
      data_rvalid = 0;
      settle();
      chk1("fp_m0_gnt", f_m0_gnt, 1'b1);
      chk1("fp_m1_gnt", f_m1_gnt, 1'b0);
      chk("fp_addr", f_data_addr, m0_addr);
      cyc();
      rd = 32'hF00D_0000 + 32'(i);
      data_rvalid = 1; data_rdata = rd;
      exp_q.push_back('{i[0], rd, 1'b1});
      settle();
      chk1("fp_m0_rvalid", f_m0_rvalid, 1'b1);
      chk1("fp_m1_rvalid", f_m1_rvalid, 1'b0);
      chk("fp_m0_rdata", f_m0_rdata, rd);
      cyc();
    end
    data_rvalid = 0; m0_req = 0; m1_req = 0; data_gnt = 0;

    // m0 with gnt delayed 3 cycles; m1 arrives in cycle 1 and must wait
    m0_addr = 32'h400; m1_addr = 32'h500; m0_req = 1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) m1_req = 1;
      data_gnt = (c == 3);
      settle();
      chk("lock_addr", r_data_addr, 32'h400);
      chk1("lock_m0_gnt", r_m0_gnt, c == 3);
      chk1("lock_m1_gnt", r_m1_gnt, 1'b0);
      cyc();
    end
    m0_req = 0; data_gnt = 1;
    settle();
    chk1("lock_resp_req", r_data_req, 1'b0);
    cyc();
    data_rvalid = 1; data_rdata = 32'h0BAD_F00D;
    exp_q.push_back('{1'b0, 32'h0BAD_F00D, 1'b1});
    settle();
    chk1("lock_rv_no_m1_gnt", r_m1_gnt, 1'b0);
    chk1("lock_rv_no_req", r_data_req, 1'b0);
    cyc();
    data_rvalid = 0;
    settle();
    chk1("lock_m1_gnt_after", r_m1_gnt, 1'b1);
    chk("lock_m1_addr", r_data_addr, 32'h500);
    cyc();
    m1_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'h0000_0505;
    exp_q.push_back('{1'b1, 32'h0000_0505, 1'b1});
    cyc();
    data_rvalid = 0;

    // Owner drops request while waiting for gnt
    m0_req = 1; m0_addr = 32'h800;
    cyc();
    m0_req = 0; m1_req = 1; m1_addr = 32'h900;
    settle();
    chk1("drop_req", r_data_req, 1'b0);
    chk("drop_addr", r_data_addr, 32'd0);
    cyc();
    data_gnt = 1;
    settle();
    chk1("drop_m1_gnt", r_m1_gnt, 1'b1);
    chk("drop_m1_addr", r_data_addr, 32'h900);
    cyc();
    m1_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'h0000_0909;
    exp_q.push_back('{1'b1, 32'h0000_0909, 1'b1});
    cyc();
    data_rvalid = 0;

    // Reset during RESP, late rvalid must be dropped
    m0_req = 1; m0_addr = 32'hA00; data_gnt = 1;
    cyc();
    m0_req = 0; data_gnt = 0;
    settle();
    rst = 1; data_rvalid = 1; data_rdata = 32'hBAD0_BAD0;
    #1;
    chk1("rst_resp_m0_rvalid", r_m0_rvalid, 1'b0);
    chk("rst_resp_m0_rdata", r_m0_rdata, 32'd0);
    chk1("rst_resp_req", r_data_req, 1'b0);
    cyc();
    rst = 0;
    settle();
    chk1("post_rst_m0_rvalid", r_m0_rvalid, 1'b0);
    chk1("post_rst_m1_rvalid", r_m1_rvalid, 1'b0);
    cyc();
    data_rvalid = 0; m1_req = 1; m1_addr = 32'hB00; data_gnt = 1;
    settle();
    chk1("post_rst_m1_gnt", r_m1_gnt, 1'b1);
    chk("post_rst_addr", r_data_addr, 32'hB00);
    cyc();
    m1_req = 0; data_gnt = 0; data_rvalid = 1; data_rdata = 32'h0000_0B0B;
    exp_q.push_back('{1'b1, 32'h0000_0B0B, 1'b1});
    cyc();
    data_rvalid = 0;
    cyc(); cyc();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
